pll_lock_reset_sequencer: RTL



---
 rtl/pll_lock_reset_sequencer.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/pll_lock_reset_sequencer.sv
// Reset sequencer for the PLL: pulses the PLL reset, qualifies a synchronized lock,
// then releases downstream domain resets in order and drops them again on lock loss.
module pll_lock_reset_sequencer #(
    parameter int NUM_STAGES     = 2,
    parameter int PLL_RST_CYCLES = 16,
    parameter int LOCK_TIMEOUT   = 100000,
    parameter int LOCK_STABLE    = 1024,
    parameter int STAGE_GAP      = 16,
    parameter int CNT_W          = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  locked,
    output logic                  pll_rst,
    output logic [NUM_STAGES-1:0] rst_out,
    output logic                  ready,
    output logic [CNT_W-1:0]      loss_count,
    output logic [CNT_W-1:0]      retry_count,
    output logic [2:0]            state
);

    typedef enum logic [2:0] {
        PLL_RST   = 3'd0,
        WAIT_LOCK = 3'd1,
        STABILIZE = 3'd2,
        RELEASE   = 3'd3,
        RUN       = 3'd4
    } state_t;

    // One shared timer serves every state, so it must hold the longest interval.
    localparam int T_A  = (LOCK_TIMEOUT > LOCK_STABLE) ? LOCK_TIMEOUT : LOCK_STABLE;
    localparam int T_B  = (PLL_RST_CYCLES > NUM_STAGES * STAGE_GAP) ? PLL_RST_CYCLES
                                                                    : NUM_STAGES * STAGE_GAP;
    localparam int TMAX = (T_A > T_B) ? T_A : T_B;
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic [TW-1:0] PLL_LAST     = TW'(PLL_RST_CYCLES - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(LOCK_TIMEOUT - 1);
    localparam logic [TW-1:0] STABLE_LAST  = TW'(LOCK_STABLE - 1);
    localparam logic [TW-1:0] RUN_AT       = TW'(NUM_STAGES * STAGE_GAP);

    state_t        cur;
    logic          sync1;
    logic          lock_s;
    logic [TW-1:0] timer;
    logic [TW-1:0] timer_inc;

    assign timer_inc = timer + TW'(1);
    assign state     = cur;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1  <= 1'b0;
            lock_s <= 1'b0;
        end else begin
            sync1  <= locked;
            lock_s <= sync1;
        end
    end

    // Lock loss is checked before any release step, so it wins over a release scheduled for the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur         <= PLL_RST;
            timer       <= '0;
            pll_rst     <= 1'b1;
            rst_out     <= '1;
            ready       <= 1'b0;
            loss_count  <= '0;
            retry_count <= '0;
        end else begin
            case (cur)
                PLL_RST: begin
                    if (timer == PLL_LAST) begin
                        cur     <= WAIT_LOCK;
                        timer   <= '0;
                        pll_rst <= 1'b0;
                    end else begin
                        timer <= timer_inc;
                    end
                end
                WAIT_LOCK: begin
                    if (lock_s) begin
                        cur   <= STABILIZE;
                        timer <= '0;
                    end else if (timer == TIMEOUT_LAST) begin
                        cur     <= PLL_RST;
                        timer   <= '0;
                        pll_rst <= 1'b1;
                        if (retry_count != '1) begin
                            retry_count <= retry_count + CNT_W'(1);
                        end
                    end else begin
                        timer <= timer_inc;
                    end
                end
                STABILIZE: begin
                    if (!lock_s) begin
                        cur   <= WAIT_LOCK;
                        timer <= '0;
                    end else if (timer == STABLE_LAST) begin
                        cur        <= RELEASE;
                        timer      <= '0;
                        rst_out[0] <= 1'b0;
                    end else begin
                        timer <= timer_inc;
                    end
                end
                RELEASE, RUN: begin
                    if (!lock_s) begin
                        cur     <= WAIT_LOCK;
                        timer   <= '0;
                        rst_out <= '1;
                        ready   <= 1'b0;
                        if (loss_count != '1) begin
                            loss_count <= loss_count + CNT_W'(1);
                        end
                    end else if (cur == RELEASE) begin
                        timer <= timer_inc;
                        for (int i = 1; i < NUM_STAGES; i++) begin
                            if (timer_inc == TW'(i * STAGE_GAP)) begin
                                rst_out[i] <= 1'b0;
                            end
                        end
                        if (timer_inc == RUN_AT) begin
                            cur   <= RUN;
                            ready <= 1'b1;
                        end
                    end
                end
                default: begin
                    cur     <= PLL_RST;
                    timer   <= '0;
                    pll_rst <= 1'b1;
                    rst_out <= '1;
                    ready   <= 1'b0;
                end
            endcase
        end
    end

endmodule
